uart_tx_fifo_reader: RTL and testbench

//  Read-side consumer of the UART TX FIFO. Pops one byte at a time from the FIFO

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_reader.sv | 102 ++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the TX reader state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// Pops bytes from the UART TX FIFO and serialises each as an 8N1 frame, LSB first,
// paced by an oversampled baud tick. The FSM state is exported on the state port.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rdata,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [1:0]           state
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_tx_state_e       fsm;
    logic [DATA_BITS-1:0] shift;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 tick_last;

    assign tick_last = b_tick && (tick_cnt == TICK_LAST);

    // Pop is combinational so the byte is latched in the same clock it is removed;
    // held low while reset is asserted so no byte is lost during reset.
    assign fifo_pop = (fsm == ST_IDLE) && !fifo_empty && !rst;
    assign tx_busy  = (fsm != ST_IDLE);
    assign state    = fsm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= ST_IDLE;
            shift    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        shift <= fifo_rdata;
                        fsm   <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (tick_last) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        fsm      <= ST_DATA;
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    tx <= shift[0];
                    if (tick_last) begin
                        tick_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            fsm <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (tick_last) begin
                        tick_cnt <= '0;
                        tx_done  <= 1'b1;
                        fsm      <= ST_IDLE;
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    tx  <= 1'b1;
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: queue-based FIFO model, tick-counting UART receiver
// as reference decoder, and an expected-byte scoreboard.
module tb_uart_tx_fifo_reader;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_pop, tx, tx_busy, tx_done;
    logic [1:0] state;

    always #5 clk = ~clk;

    uart_tx_fifo_reader dut (
        .clk(clk), .rst(rst), .b_tick(b_tick), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop), .tx(tx),
        .tx_busy(tx_busy), .tx_done(tx_done), .state(state)
    );

    int errors = 0, checks = 0;
    logic [7:0] fifo_q[$], push_q[$], exp_q[$];
    int run_q[$];
    int tick_period = 1, cyc = 0;
    bit stall = 0, pop_pending = 0, phase_idle = 0;
    int pops = 0, pop_empty_err = 0, pop_busy_err = 0, pop_run = 0, pop_run_max = 0;
    int done_cnt = 0, done_wide_err = 0, last_done_cyc = 0, idle_err = 0;
    int frames = 0, mon_ticks = 0, fall_cyc = 0, last_gap = 0, run_len = 0;
    bit in_frame = 0, prev_done = 0;
    logic prev_tx = 1'b1;
    logic [7:0] rx_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, frames, target);
    endtask

    task automatic wait_ticks(input int t, input int budget, input string name);
        int n = 0;
        while (!(in_frame && mon_ticks >= t) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (in_frame && mon_ticks >= t), 1);
    endtask

    // FIFO model and tick driver: inputs change 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pop_pending) begin
                if (fifo_q.size() == 0) pop_empty_err++;
                else begin
                    void'(fifo_q.pop_front());
                    pops++;
                end
            end
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            fifo_empty = (fifo_q.size() == 0);
            fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
            b_tick = !stall && (cyc % tick_period == 0);
        end
    end

    // Monitor: samples on the falling edge, decodes frames by counting baud ticks.
    initial begin
        forever begin
            @(negedge clk);
            pop_pending = fifo_pop;
            if (fifo_pop) begin
                pop_run++;
                if (tx_busy) pop_busy_err++;
            end else pop_run = 0;
            if (pop_run > pop_run_max) pop_run_max = pop_run;
            if (tx_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (prev_done) done_wide_err++;
            end
            prev_done = tx_done;
            if (tx !== prev_tx) begin
                run_q.push_back(run_len);
                run_len = 1;
            end else run_len++;
            prev_tx = tx;
            if (phase_idle && (tx !== 1'b1 || fifo_pop || tx_busy || tx_done)) idle_err++;
            if (rst) in_frame = 0;
            else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1;
                    mon_ticks = 0;
                    fall_cyc = cyc;
                    last_gap = cyc - last_done_cyc;
                    rx_byte = 8'h00;
                end
            end else if (b_tick) begin
                mon_ticks++;
                if (mon_ticks >= 8 && (mon_ticks - 8) % 16 == 0) begin
                    int k;
                    k = (mon_ticks - 8) / 16;
                    if (k == 0) check("start_bit", tx, 0);
                    else if (k <= 8) rx_byte[k-1] = tx;
                    else begin
                        check("stop_bit", tx, 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_data: got %0d expected none", rx_byte);
                        end else check("frame_data", rx_byte, exp_q.pop_front());
                        frames++;
                        in_frame = 0;
                    end
                end
            end
        end
    end

    initial begin
        int p0, d0, f0, bad, tx_err, st_err;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_pop", fifo_pop, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_state", state, ST_IDLE);
        @(posedge clk); #1 rst = 0;

        // Empty FIFO: line must stay idle.
        phase_idle = 1;
        repeat (1000) @(posedge clk);
        phase_idle = 0;
        check("idle_quiet", idle_err, 0);

        // Single byte 0x55: alternating bits give one run per bit.
        run_q.delete();
        p0 = pops; d0 = done_cnt; f0 = frames; pop_run_max = 0;
        push_byte(8'h55);
        wait_frames(f0 + 1, 1000, "t2_frame");
        repeat (20) @(posedge clk);
        check("t2_pops", pops - p0, 1);
        check("t2_done", done_cnt - d0, 1);
        check("t2_pop_width", pop_run_max, 1);
        check_range("t2_runs", run_q.size(), 10, 100);
        bad = 0;
        for (int i = 1; i <= 9 && i < run_q.size(); i++)
            if (run_q[i] < 15 || run_q[i] > 17) bad++;
        check("t2_bit_width", bad, 0);

        // Two queued bytes back-to-back.
        p0 = pops; d0 = done_cnt; f0 = frames;
        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_frames(f0 + 2, 2000, "t3_frames");
        repeat (20) @(posedge clk);
        check("t3_pops", pops - p0, 2);
        check("t3_done", done_cnt - d0, 2);
        check_range("t3_gap", last_gap, 1, 2);

        // Tick stall inside data bit 3 of 0x0F.
        f0 = frames;
        push_byte(8'h0F);
        wait_ticks(70, 500, "t4_reach_bit3");
        stall = 1;
        @(negedge clk);
        @(negedge clk);
        tx_err = 0; st_err = 0;
        for (int i = 0; i < 198; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_err++;
            if (state !== ST_DATA) st_err++;
        end
        check("t4_stall_tx", tx_err, 0);
        check("t4_stall_state", st_err, 0);
        @(posedge clk); #1 stall = 0;
        wait_frames(f0 + 1, 1000, "t4_frame");
        repeat (20) @(posedge clk);

        // Async reset during data bit 4 of 0xF0; 0x96 still queued.
        p0 = pops; f0 = frames;
        push_byte(8'hF0);
        push_byte(8'h96);
        wait_ticks(86, 500, "t5_reach_bit4");
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_pop", fifo_pop, 0);
        void'(exp_q.pop_front());
        repeat (3) @(posedge clk);
        #1 rst = 0;
        wait_frames(f0 + 1, 1000, "t5_frame");
        repeat (20) @(posedge clk);
        check("t5_pops", pops - p0, 2);
        check("t5_fifo_empty", fifo_empty, 1);

        // Slow tick (every 3 clks), byte 0x80.
        tick_period = 3;
        run_q.delete();
        f0 = frames;
        push_byte(8'h80);
        wait_frames(f0 + 1, 2000, "t6_frame");
        repeat (60) @(posedge clk);
        check_range("t6_low_run", (run_q.size() > 1) ? run_q[1] : 0, 381, 387);
        check_range("t6_frame_len", last_done_cyc - fall_cyc, 477, 483);

        check("end_exp_empty", exp_q.size(), 0);
        check("end_frames", frames, 6);
        check("end_done_cnt", done_cnt, 6);
        check("end_pops", pops, 7);
        check("end_pop_empty", pop_empty_err, 0);
        check("end_pop_busy", pop_busy_err, 0);
        check("end_done_width", done_wide_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
